// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its downstream execution unit.
//   opcode_t      : 4-bit opcode. Encodings 8..15 are unused and treated as
//                   illegal by consumers.
//   operand_t     : signed 32-bit operand.
//   address_t     : 5-bit register address (32 entries).
//   instruction_t : one stored instruction word {opc, op_a, op_b}.
// -----------------------------------------------------------------------------
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

endpackage

// File: rtl/instr_exec_unit_if.sv
// -----------------------------------------------------------------------------
// instr_exec_unit_if
// Result channel of the execution unit (valid/ready handshake).
//   result       : signed RES_W-bit arithmetic result
//   result_opc   : opcode that produced the result
//   result_ptr   : source address of the instruction
//   result_err   : divide-by-zero or illegal opcode
//   result_valid : producer has a result on the bus
//   result_ready : consumer accepts the result
// master = execution unit, slave = result consumer.
// -----------------------------------------------------------------------------
interface instr_exec_unit_if #(
    parameter int RES_W = 64
) ();

    logic signed [RES_W-1:0]      result;
    instr_register_pkg::opcode_t  result_opc;
    instr_register_pkg::address_t result_ptr;
    logic                         result_err;
    logic                         result_valid;
    logic                         result_ready;

    modport master (
        output result,
        output result_opc,
        output result_ptr,
        output result_err,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_opc,
        input  result_ptr,
        input  result_err,
        input  result_valid,
        output result_ready
    );

endinterface

// File: rtl/instr_exec_unit.sv
// -----------------------------------------------------------------------------
// instr_exec_unit
// Execution stage behind instr_register. A start command runs a batch of
// 1..32 consecutive instructions beginning at first_ptr (addresses wrap 31->0).
// For each instruction the unit fetches the word at read_pointer, computes the
// result and offers it on the result channel until it is accepted.
//
// Ports:
//   clk              : clock, rising edge
//   reset_n          : asynchronous active-low reset
//   start            : batch request, only looked at in IDLE
//   first_ptr        : first instruction address of the batch
//   count            : number of instructions, 0..32
//   instruction_word : combinational read data from instr_register
//   read_pointer     : registered read address to instr_register
//   res              : result channel (master side of instr_exec_unit_if)
//   busy             : high whenever the FSM is not IDLE
//   done             : one-cycle pulse when a batch completes
// -----------------------------------------------------------------------------
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int RES_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     first_ptr,
    input  logic [5:0]   count,
    input  instruction_t instruction_word,
    output address_t     read_pointer,
    instr_exec_unit_if.master res,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q,      state_d;
    address_t                rd_ptr_q,     rd_ptr_d;
    logic [5:0]              remaining_q,  remaining_d;
    instruction_t            instr_q,      instr_d;
    logic signed [RES_W-1:0] result_q,     result_d;
    opcode_t                 result_opc_q, result_opc_d;
    address_t                result_ptr_q, result_ptr_d;
    logic                    result_err_q, result_err_d;

    // ---------------------------------------------------------------------
    // Arithmetic on the captured instruction word
    // ---------------------------------------------------------------------
    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] alu_res;
    logic                    alu_err;

    always_comb begin
        a_ext   = {{(RES_W-32){instr_q.op_a[31]}}, instr_q.op_a};
        b_ext   = {{(RES_W-32){instr_q.op_b[31]}}, instr_q.op_b};
        alu_res = '0;
        alu_err = 1'b0;
        case (instr_q.opc)
            ZERO:  alu_res = '0;
            PASSA: alu_res = a_ext;
            PASSB: alu_res = b_ext;
            ADD:   alu_res = a_ext + b_ext;
            SUB:   alu_res = a_ext - b_ext;
            MULT:  alu_res = a_ext * b_ext;
            // Signed / and % truncate toward zero, so % follows the sign of a.
            DIV: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_res = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_res = a_ext % b_ext;
            end
            default: alu_err = 1'b1;    // encodings outside the enum
        endcase
    end

    // ---------------------------------------------------------------------
    // Control FSM: next state and datapath register updates
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        remaining_d  = remaining_q;
        instr_d      = instr_q;
        result_d     = result_q;
        result_opc_d = result_opc_q;
        result_ptr_d = result_ptr_q;
        result_err_d = result_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != 6'd0) begin
                        rd_ptr_d    = first_ptr;
                        remaining_d = count;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                instr_d = instruction_word;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d     = alu_res;
                result_opc_d = instr_q.opc;
                result_ptr_d = rd_ptr_q;
                result_err_d = alu_err;
                state_d      = S_OUT;
            end
            S_OUT: begin
                if (res.result_ready) begin
                    rd_ptr_d    = rd_ptr_q + 5'd1;    // natural 5-bit wrap 31->0
                    remaining_d = remaining_q - 6'd1;
                    state_d     = (remaining_q == 6'd1) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            remaining_q  <= '0;
            instr_q      <= '0;
            result_q     <= '0;
            result_opc_q <= ZERO;
            result_ptr_q <= '0;
            result_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            remaining_q  <= remaining_d;
            instr_q      <= instr_d;
            result_q     <= result_d;
            result_opc_q <= result_opc_d;
            result_ptr_q <= result_ptr_d;
            result_err_q <= result_err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: all decoded from registered state
    // ---------------------------------------------------------------------
    assign read_pointer     = rd_ptr_q;
    assign res.result       = result_q;
    assign res.result_opc   = result_opc_q;
    assign res.result_ptr   = result_ptr_q;
    assign res.result_err   = result_err_q;
    assign res.result_valid = (state_q == S_OUT);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_exec_unit
// Directed bench for instr_exec_unit. A behavioural instruction register feeds
// the DUT; each batch pushes its hand-computed results into a queue and a
// negedge monitor pops and compares every accepted result.
// -----------------------------------------------------------------------------
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    localparam int RES_W = 64;

    typedef struct {
        logic signed [RES_W-1:0] res;
        opcode_t                 opc;
        address_t                ptr;
        logic                    err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     first_ptr;
    logic [5:0]   count;
    instruction_t instruction_word;
    address_t     read_pointer;
    logic         busy;
    logic         done;

    instr_exec_unit_if #(.RES_W(RES_W)) res_if ();

    instr_exec_unit #(.RES_W(RES_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_ptr        (first_ptr),
        .count            (count),
        .instruction_word (instruction_word),
        .read_pointer     (read_pointer),
        .res              (res_if.master),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Behavioural instruction register plus hand-computed expected results
    instruction_t            mem     [32];
    logic signed [RES_W-1:0] exp_res [32];
    logic                    exp_err [32];

    assign instruction_word = mem[read_pointer];

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input logic [RES_W-1:0] act,
                         input logic [RES_W-1:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, $signed(act), act, $signed(req), req);
        end
    endtask

    // Monitor: compares every result at the cycle it is handed over
    always @(negedge clk) begin
        if (reset_n && res_if.result_valid && res_if.result_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result",     res_if.result,     e.res);
                check("result_opc", 64'(res_if.result_opc), 64'(e.opc));
                check("result_ptr", 64'(res_if.result_ptr), 64'(e.ptr));
                check("result_err", 64'(res_if.result_err), 64'(e.err));
                $display("[TB] result ptr=%0d opc=%0d res=%0d err=%0b",
                         res_if.result_ptr, res_if.result_opc,
                         $signed(res_if.result), res_if.result_err);
            end
        end
    end

    task automatic load(input int addr, input opcode_t opc, input int a, input int b,
                        input logic signed [RES_W-1:0] r, input logic e);
        mem[addr]     = '{opc: opc, op_a: a, op_b: b};
        exp_res[addr] = r;
        exp_err[addr] = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected results for a batch, then pulse start for one edge
    task automatic start_batch(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int ad;
            exp_t e;
            ad    = (first + i) % 32;
            e.res = exp_res[ad];
            e.opc = mem[ad].opc;
            e.ptr = address_t'(ad);
            e.err = exp_err[ad];
            exp_q.push_back(e);
        end
        first_ptr = address_t'(first);
        count     = 6'(cnt);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
        check({name, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_read_pointer"}, 64'(read_pointer), 64'd0);
        check({name, "_result"},       res_if.result, 64'd0);
        check({name, "_result_opc"},   64'(res_if.result_opc), 64'(ZERO));
        check({name, "_result_ptr"},   64'(res_if.result_ptr), 64'd0);
        check({name, "_result_err"},   64'(res_if.result_err), 64'd0);
        check({name, "_result_valid"}, 64'(res_if.result_valid), 64'd0);
        check({name, "_busy"},         64'(busy), 64'd0);
        check({name, "_done"},         64'(done), 64'd0);
    endtask

    initial begin
        int n;
        logic signed [RES_W-1:0] held_res;

        for (int i = 0; i < 32; i++) load(i, ZERO, 0, 0, 64'sd0, 1'b0);
        reset_n             = 1'b0;
        start               = 1'b0;
        first_ptr           = '0;
        count               = '0;
        res_if.result_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // ---------------- single ADD, exact latency ----------------
        load(0, ADD, 5, 7, 64'sd12, 1'b0);
        start_batch(0, 1);                           // now in cycle 1
        check("lat_c1_valid", 64'(res_if.result_valid), 64'd0);
        check("lat_c1_busy",  64'(busy), 64'd1);
        tick();                                      // cycle 2
        check("lat_c2_valid", 64'(res_if.result_valid), 64'd0);
        tick();                                      // cycle 3
        check("lat_c3_valid", 64'(res_if.result_valid), 64'd1);
        check("lat_c3_done",  64'(done), 64'd0);
        tick();                                      // cycle 4
        check("lat_c4_done",  64'(done), 64'd1);
        check("lat_c4_valid", 64'(res_if.result_valid), 64'd0);
        tick();                                      // cycle 5
        check("lat_c5_busy",  64'(busy), 64'd0);
        check("lat_c5_done",  64'(done), 64'd0);
        check("lat_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // ---------------- all opcodes, a=-7 b=2 ----------------
        load(0, ZERO,  -7, 2,  64'sd0,  1'b0);
        load(1, PASSA, -7, 2, -64'sd7,  1'b0);
        load(2, PASSB, -7, 2,  64'sd2,  1'b0);
        load(3, ADD,   -7, 2, -64'sd5,  1'b0);
        load(4, SUB,   -7, 2, -64'sd9,  1'b0);
        load(5, MULT,  -7, 2, -64'sd14, 1'b0);
        load(6, DIV,   -7, 2, -64'sd3,  1'b0);
        load(7, MOD,   -7, 2, -64'sd1,  1'b0);
        start_batch(0, 8);
        wait_done("opcodes");

        // ---------------- divide by zero, illegal opcode, wide product ----------------
        load(8,  DIV,  10, 0, 64'sd0, 1'b1);
        load(9,  MOD,  10, 3, 64'sd1, 1'b0);
        load(10, opcode_t'(4'd12), 3, 4, 64'sd0, 1'b1);
        load(11, MULT, 100000, -300000, -64'sd30000000000, 1'b0);
        start_batch(8, 4);
        wait_done("errors");

        // ---------------- backpressure ----------------
        load(12, ADD, 3, 4, 64'sd7, 1'b0);
        res_if.result_ready = 1'b0;
        start_batch(12, 1);
        n = 0;
        while (!res_if.result_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_valid_seen", 64'(res_if.result_valid), 64'd1);
        held_res = res_if.result;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", 64'(res_if.result_valid), 64'd1);
            check("bp_result_held", res_if.result, held_res);
            check("bp_rdptr_held", 64'(read_pointer), 64'd12);
        end
        res_if.result_ready = 1'b1;
        tick();
        check("bp_rdptr_adv", 64'(read_pointer), 64'd13);
        wait_done("bp");

        // ---------------- wrap-around with ignored mid-batch start ----------------
        load(30, SUB,   1,   2,  -64'sd1,   1'b0);
        load(31, PASSA, 123, 9,   64'sd123, 1'b0);
        start_batch(30, 4);                          // 0,1 still ZERO / PASSA(-7)
        repeat (4) tick();
        first_ptr = 5'd5;
        count     = 6'd3;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_done("wrap");

        // ---------------- count = 0 ----------------
        first_ptr = 5'd3;
        count     = 6'd0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("cnt0_done", 64'(done), 64'd1);
        check("cnt0_valid", 64'(res_if.result_valid), 64'd0);
        tick();
        check("cnt0_busy", 64'(busy), 64'd0);
        check("cnt0_done_pulse", 64'(done), 64'd0);

        // ---------------- reset during EXEC ----------------
        start_batch(8, 2);                           // cycle 1 = FETCH
        tick();                                      // cycle 2 = EXEC
        check("abort_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 64'(done), 64'd0);
        end
        reset_n = 1'b1;
        tick();
        check("abort_idle_done", 64'(done), 64'd0);
        start_batch(8, 2);
        wait_done("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
